// File: rtl/data_path.sv
// Single-cycle RV32 integer datapath: PC, instruction ROM, register file, immediate
// generator, ALU and data RAM. Control comes from an external controller.
module data_path #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned DMEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic              mem2reg,
    input  logic              alu_src,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [3:0]        alu_cc,
    output logic [6:0]        opcode,
    output logic [6:0]        funct7,
    output logic [2:0]        funct3,
    output logic [DATA_W-1:0] alu_result
);

    localparam int unsigned IAW       = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW       = $clog2(DMEM_DEPTH);
    localparam int unsigned PCW       = IAW + 2;
    localparam int unsigned ROM_WORDS = 20;
    localparam int unsigned RIW       = $clog2(ROM_WORDS);

    localparam logic [31:0] ROM [ROM_WORDS] = '{
        32'h00007033, 32'h00100093, 32'h00200113, 32'h00308193,
        32'h00408213, 32'h00510293, 32'h00610313, 32'h00718393,
        32'h00208433, 32'h404404b3, 32'h00317533, 32'h0041e5b3,
        32'h0041a633, 32'h007346b3, 32'h4d34f713, 32'h8d35e793,
        32'h4d26a813, 32'h4d244893, 32'h02b02823, 32'h03002983
    };

    logic [PCW-1:0]    pc_q, pc_d;
    logic [IAW-1:0]    iidx;
    logic [31:0]       instr;
    logic [4:0]        rs1, rs2, rd;
    logic [DATA_W-1:0] rs1_data, rs2_data, imm, op_b, rdata, wb_data;
    logic [DAW-1:0]    daddr;
    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rf_d [32];
    logic [DATA_W-1:0] mem_q [DMEM_DEPTH];
    logic [DATA_W-1:0] mem_d [DMEM_DEPTH];
    logic              unused_bits;

    // PC steps one word per cycle; its width makes the wrap implicit.
    always_comb begin
        pc_d = pc_q + PCW'(4);
    end

    // PC register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    // Instruction fetch and field decode; words past the program read as zero.
    always_comb begin
        iidx  = pc_q[PCW-1:2];
        instr = '0;
        if (iidx < IAW'(ROM_WORDS)) instr = ROM[iidx[RIW-1:0]];
        rs1 = instr[19:15];
        rs2 = instr[24:20];
        rd  = instr[11:7];
    end

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];

    // Register reads and immediate generation.
    always_comb begin
        rs1_data = (rs1 == 5'd0) ? '0 : rf_q[rs1];
        rs2_data = (rs2 == 5'd0) ? '0 : rf_q[rs2];
        unique case (opcode)
            7'b0000011, 7'b0010011: imm = {{(DATA_W-12){instr[31]}}, instr[31:20]};
            7'b0100011:             imm = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
            default:                imm = '0;
        endcase
        op_b = alu_src ? imm : rs2_data;
    end

    // ALU.
    always_comb begin
        case (alu_cc)
            4'b0000: alu_result = rs1_data & op_b;
            4'b0001: alu_result = rs1_data | op_b;
            4'b0010: alu_result = rs1_data + op_b;
            4'b0110: alu_result = rs1_data - op_b;
            4'b0111: alu_result = {{(DATA_W-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
            4'b1100: alu_result = ~(rs1_data | op_b);
            default: alu_result = '0;
        endcase
    end

    // RAM read (old data on same-cycle write), writeback select and next-state for storage.
    always_comb begin
        daddr   = alu_result[DAW+1:2];
        rdata   = mem_read ? mem_q[daddr] : '0;
        wb_data = mem2reg ? rdata : alu_result;
        rf_d    = rf_q;
        mem_d   = mem_q;
        if (reg_write && (rd != 5'd0)) rf_d[rd] = wb_data;
        if (mem_write) mem_d[daddr] = rs2_data;
    end

    // Register file and RAM storage, both cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
            for (int i = 0; i < int'(DMEM_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            rf_q  <= rf_d;
            mem_q <= mem_d;
        end
    end

    assign unused_bits = ^{pc_q[1:0], alu_result[DATA_W-1:DAW+2], alu_result[1:0]};

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: ISA-level reference model, controller modelled from decoded fields,
// directed program replay plus a randomized control phase.
module tb_data_path;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write, mem2reg, alu_src, mem_write, mem_read;
    logic [3:0]  alu_cc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] alu_result;

    int checks   = 0;
    int failures = 0;
    bit rand_mode = 1'b0;

    logic [31:0] m_rom  [64];
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [128];
    int          m_pc;

    logic [31:0] exp_prog [20] = '{
        32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hB,
        32'h3, 32'hFFFFFFFE, 32'h0, 32'h5, 32'h1, 32'hFFFFFFF4,
        32'h4D2, 32'hFFFFF8D7, 32'h1, 32'hFFFFFB2C, 32'h30, 32'h30
    };

    data_path dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .mem2reg    (mem2reg),
        .alu_src    (alu_src),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .alu_cc     (alu_cc),
        .opcode     (opcode),
        .funct7     (funct7),
        .funct3     (funct3),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        for (int i = 0; i < 128; i++) m_mem[i] = 32'h0;
    endtask

    // Reference: evaluate the current instruction with the currently applied controls.
    task automatic predict(output logic [31:0] instr, output logic [31:0] res,
                           output logic [31:0] rdat);
        logic [31:0] a, b, imm;
        int opc;
        instr = m_rom[(m_pc / 4) % 64];
        opc   = int'(instr[6:0]);
        if (opc == 3 || opc == 19)  imm = 32'($signed(instr[31:20]));
        else if (opc == 35)         imm = 32'($signed({instr[31:25], instr[11:7]}));
        else                        imm = 32'h0;
        a = m_regs[instr[19:15]];
        b = alu_src ? imm : m_regs[instr[24:20]];
        case (alu_cc)
            4'd0:    res = a & b;
            4'd1:    res = a | b;
            4'd2:    res = a + b;
            4'd6:    res = a - b;
            4'd7:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   res = ~(a | b);
            default: res = 32'h0;
        endcase
        rdat = mem_read ? m_mem[(res / 4) % 128] : 32'h0;
    endtask

    // Commit of one clock edge in the reference model.
    task automatic model_commit();
        logic [31:0] instr, res, rdat, sdata;
        predict(instr, res, rdat);
        sdata = m_regs[instr[24:20]];
        if (mem_write) m_mem[(res / 4) % 128] = sdata;
        if (reg_write && instr[11:7] != 5'd0) m_regs[instr[11:7]] = mem2reg ? rdat : res;
        m_pc = (m_pc + 4) % 256;
    endtask

    task automatic compare_now();
        logic [31:0] instr, res, rdat;
        predict(instr, res, rdat);
        check("opcode", {25'h0, opcode}, {25'h0, instr[6:0]});
        check("funct7", {25'h0, funct7}, {25'h0, instr[31:25]});
        check("funct3", {29'h0, funct3}, {29'h0, instr[14:12]});
        check("alu_result", alu_result, res);
    endtask

    // Controller decoded from the fields the DUT presents, or random controls.
    task automatic drive_controls();
        if (rand_mode) begin
            reg_write = 1'($urandom_range(0, 1));
            mem2reg   = 1'($urandom_range(0, 1));
            alu_src   = 1'($urandom_range(0, 1));
            mem_write = 1'($urandom_range(0, 1));
            mem_read  = 1'($urandom_range(0, 1));
            alu_cc    = 4'($urandom_range(0, 15));
            return;
        end
        {reg_write, mem2reg, alu_src, mem_write, mem_read} = 5'b0;
        alu_cc = 4'b0000;
        case (opcode)
            7'b0110011, 7'b0010011: begin
                reg_write = 1'b1;
                alu_src   = (opcode == 7'b0010011);
                case (funct3)
                    3'b000:  alu_cc = (opcode == 7'b0110011 && funct7[5]) ? 4'b0110 : 4'b0010;
                    3'b111:  alu_cc = 4'b0000;
                    3'b110:  alu_cc = 4'b0001;
                    3'b010:  alu_cc = 4'b0111;
                    3'b100:  alu_cc = 4'b1100;
                    default: alu_cc = 4'b1111;
                endcase
            end
            7'b0000011: begin
                {reg_write, mem2reg, alu_src, mem_read} = 4'b1111;
                alu_cc = 4'b0010;
            end
            7'b0100011: begin
                {alu_src, mem_write} = 2'b11;
                alu_cc = 4'b0010;
            end
            default: ;
        endcase
    endtask

    // One cycle: edge commit, new controls just after the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) model_commit();
        #1;
        drive_controls();
        @(negedge clk);
        compare_now();
    endtask

    task automatic run_program(input string tag);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("%s_word%0d", tag, k), alu_result, exp_prog[k]);
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_rom[i] = 32'h0;
        m_rom[0]  = 32'h00007033; m_rom[1]  = 32'h00100093; m_rom[2]  = 32'h00200113;
        m_rom[3]  = 32'h00308193; m_rom[4]  = 32'h00408213; m_rom[5]  = 32'h00510293;
        m_rom[6]  = 32'h00610313; m_rom[7]  = 32'h00718393; m_rom[8]  = 32'h00208433;
        m_rom[9]  = 32'h404404b3; m_rom[10] = 32'h00317533; m_rom[11] = 32'h0041e5b3;
        m_rom[12] = 32'h0041a633; m_rom[13] = 32'h007346b3; m_rom[14] = 32'h4d34f713;
        m_rom[15] = 32'h8d35e793; m_rom[16] = 32'h4d26a813; m_rom[17] = 32'h4d244893;
        m_rom[18] = 32'h02b02823; m_rom[19] = 32'h03002983;
        model_clear();

        reset = 1'b0;
        {reg_write, mem2reg, alu_src, mem_write, mem_read} = 5'b0;
        alu_cc = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        check("rst_opcode", {25'h0, opcode}, 32'h33);
        check("rst_funct7", {25'h0, funct7}, 32'h0);
        check("rst_funct3", {29'h0, funct3}, 32'h7);
        check("rst_alu_result", alu_result, 32'h0);
        drive_controls();
        reset = 1'b1;
        compare_now();

        run_program("pass1");
        check("x19_after_lw", dut.rf_q[19], 32'h5);
        check("model_x19", m_regs[19], 32'h5);
        check("model_ram12", m_mem[12], 32'h5);

        // Run off the end of the ROM and through the wrap back to word 0.
        repeat (44) step();
        check("wrap_pc", 32'(m_pc), 32'h0);
        check("wrap_opcode", {25'h0, opcode}, 32'h33);
        repeat (10) step();

        // Reset asserted while word 10 is executing.
        check("pre_reset_alu", alu_result, 32'h0);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("midrst_alu_result", alu_result, 32'h0);
        check("midrst_opcode", {25'h0, opcode}, 32'h33);
        check("midrst_funct3", {29'h0, funct3}, 32'h7);
        check("midrst_x4", dut.rf_q[4], 32'h0);
        check("midrst_ram12", dut.mem_q[12], 32'h0);
        drive_controls();
        step();
        step();
        reset = 1'b1;
        run_program("replay");

        // Randomized controls, with occasional reset pulses between edges.
        rand_mode = 1'b1;
        drive_controls();
        #1;
        compare_now();
        for (int n = 0; n < 1500; n++) begin
            step();
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0;
                model_clear();
                #1;
                compare_now();
                #1;
                reset = 1'b1;
            end
        end
        check("x0_final", dut.rf_q[0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
